// File: rtl/timer_ctrl_if.sv
// Control/status bundle between the countdown sequencer and its 4-digit counter chain.
interface timer_ctrl_if;
  logic       load_req;
  logic       start;
  logic       stop;
  logic       abort;
  logic       tick;
  logic [3:0] dig_tc;
  logic       dig_loadn;
  logic       dig_clrn;
  logic [3:0] dig_en;
  logic [2:0] state;
  logic       busy;
  logic       done;
  logic       alarm;

  modport slave (
    input  load_req, start, stop, abort, tick, dig_tc,
    output dig_loadn, dig_clrn, dig_en, state, busy, done, alarm
  );
  modport master (
    output load_req, start, stop, abort, tick, dig_tc,
    input  dig_loadn, dig_clrn, dig_en, state, busy, done, alarm
  );
endinterface

// File: rtl/timer_ctrl.sv
// Countdown sequencer for a 4-digit down-counter chain (digit 0 = LSD).
// Optional macro TIMER_CTRL_AUTORELOAD_EN: on reaching zero, reload the preset and restart.
module timer_ctrl (
  input  logic        clock,
  input  logic        clr,
  timer_ctrl_if.slave bus
);
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t     r_state, w_next;
  logic       r_done, r_alarm;
  logic       w_loadn, w_clrn;
  logic [3:0] w_en;
  logic       w_zero;
`ifdef TIMER_CTRL_AUTORELOAD_EN
  logic       r_reload, w_reload;
`endif

  assign w_zero = (bus.dig_tc == 4'b1111);

  always_comb begin
    w_next  = r_state;
    w_en    = 4'b0000;
    w_loadn = 1'b1;
    w_clrn  = 1'b1;
`ifdef TIMER_CTRL_AUTORELOAD_EN
    w_reload = 1'b0;
`endif
    if (clr) begin
      w_next = S_IDLE;
      w_clrn = 1'b0;
    end else if (bus.abort) begin
      w_next = S_IDLE;
      w_clrn = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.load_req)               w_next = S_LOAD;
          else if (bus.start && !w_zero)  w_next = S_RUN;
        end
        S_LOAD: begin
          w_loadn = 1'b0;
          w_en    = 4'b1111;
`ifdef TIMER_CTRL_AUTORELOAD_EN
          w_next  = r_reload ? S_RUN : S_IDLE;
`else
          w_next  = S_IDLE;
`endif
        end
        S_RUN: begin
          if (bus.stop) begin
            w_next = S_PAUSE;
          end else if (bus.tick) begin
            if (w_zero) begin
              w_next = S_DONE;
            end else begin
              // Borrow ripples up only through digits that are already zero.
              w_en = {&bus.dig_tc[2:0], &bus.dig_tc[1:0], bus.dig_tc[0], 1'b1};
            end
          end
        end
        S_PAUSE: begin
          if (bus.start) w_next = S_RUN;
        end
        S_DONE: begin
`ifdef TIMER_CTRL_AUTORELOAD_EN
          w_next   = S_LOAD;
          w_reload = 1'b1;
`else
          if (bus.start) w_next = S_IDLE;
`endif
        end
        default: w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (clr) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
      r_alarm <= 1'b0;
    end else begin
      r_state <= w_next;
      r_done  <= (w_next == S_DONE) && (r_state != S_DONE);
      r_alarm <= (w_next == S_DONE);
    end
  end

`ifdef TIMER_CTRL_AUTORELOAD_EN
  always_ff @(posedge clock) begin
    if (clr) r_reload <= 1'b0;
    else     r_reload <= w_reload;
  end
`endif

  assign bus.state     = r_state;
  assign bus.done      = r_done;
  assign bus.alarm     = r_alarm;
  assign bus.dig_en    = w_en;
  assign bus.dig_loadn = w_loadn;
  assign bus.dig_clrn  = w_clrn;
  assign bus.busy      = (r_state == S_RUN) || (r_state == S_PAUSE);
endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl: hand-computed vectors, immediate assertions per check.
module tb_timer_ctrl;
  logic clk = 1'b0;
  logic clr;
  int   n_chk  = 0;
  int   n_fail = 0;

  timer_ctrl_if ifc();

  timer_ctrl u_dut (
    .clock (clk),
    .clr   (clr),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    ifc.load_req = 0; ifc.start = 0; ifc.stop = 0; ifc.abort = 0; ifc.tick = 0;
  endtask

  initial begin
    clr = 1'b1;
    idle_in();
    ifc.dig_tc = 4'b0000;
    #1;
    chk("clr_clrn", ifc.dig_clrn, 1'b0);
    chk("clr_en", ifc.dig_en, 4'h0);
    cyc();
    clr = 1'b0;
    #1;
    chk("rst_state", ifc.state, 3'd0);
    chk("rst_done", ifc.done, 1'b0);
    chk("rst_alarm", ifc.alarm, 1'b0);
    chk("rst_busy", ifc.busy, 1'b0);
    chk("rst_loadn", ifc.dig_loadn, 1'b1);
    chk("rst_clrn", ifc.dig_clrn, 1'b1);

    // Load pulse
    ifc.load_req = 1;
    cyc();
    ifc.load_req = 0;
    #1;
    chk("load_state", ifc.state, 3'd1);
    chk("load_loadn", ifc.dig_loadn, 1'b0);
    chk("load_en", ifc.dig_en, 4'hF);
    cyc();
    chk("load_back", ifc.state, 3'd0);
    chk("idle_loadn", ifc.dig_loadn, 1'b1);

    // Start with all digits zero is refused
    ifc.dig_tc = 4'hF; ifc.start = 1;
    cyc();
    chk("start_zero", ifc.state, 3'd0);

    ifc.dig_tc = 4'h0;
    cyc();
    ifc.start = 0;
    #1;
    chk("run_state", ifc.state, 3'd2);
    chk("run_busy", ifc.busy, 1'b1);
    chk("run_noTick_en", ifc.dig_en, 4'h0);

    ifc.tick = 1; ifc.dig_tc = 4'b0011; #1;
    chk("ripple_0011", ifc.dig_en, 4'b0111);
    ifc.dig_tc = 4'b0000; #1;
    chk("ripple_0000", ifc.dig_en, 4'b0001);
    ifc.dig_tc = 4'b0111; #1;
    chk("ripple_0111", ifc.dig_en, 4'b1111);
    ifc.dig_tc = 4'b1101; #1;
    chk("ripple_1101", ifc.dig_en, 4'b0011);

    // Stop beats a coincident tick
    ifc.dig_tc = 4'b0000; ifc.stop = 1; #1;
    chk("stop_tick_en", ifc.dig_en, 4'h0);
    cyc();
    ifc.stop = 0;
    #1;
    chk("pause_state", ifc.state, 3'd3);
    chk("pause_busy", ifc.busy, 1'b1);
    chk("pause_tick_en", ifc.dig_en, 4'h0);
    cyc();
    chk("pause_hold", ifc.state, 3'd3);
    ifc.tick = 0; ifc.start = 1;
    cyc();
    ifc.start = 0;
    #1;
    chk("resume_state", ifc.state, 3'd2);

    // Reach zero
    ifc.tick = 1; ifc.dig_tc = 4'hF; #1;
    chk("zero_en", ifc.dig_en, 4'h0);
    cyc();
    ifc.tick = 0;
    #1;
    chk("done_state", ifc.state, 3'd4);
    chk("done_pulse", ifc.done, 1'b1);
    chk("done_alarm", ifc.alarm, 1'b1);
    chk("done_busy", ifc.busy, 1'b0);
`ifdef TIMER_CTRL_AUTORELOAD_EN
    cyc();
    chk("ar_load_state", ifc.state, 3'd1);
    chk("ar_loadn", ifc.dig_loadn, 1'b0);
    chk("ar_done_low", ifc.done, 1'b0);
    ifc.dig_tc = 4'h0;
    cyc();
    chk("ar_run_state", ifc.state, 3'd2);
    ifc.abort = 1;
    cyc();
    ifc.abort = 0;
    #1;
    chk("ar_abort_state", ifc.state, 3'd0);
`else
    cyc();
    chk("done_hold", ifc.state, 3'd4);
    chk("done_oneshot", ifc.done, 1'b0);
    chk("alarm_hold", ifc.alarm, 1'b1);
    ifc.start = 1;
    cyc();
    ifc.start = 0;
    #1;
    chk("done_exit", ifc.state, 3'd0);
    chk("alarm_off", ifc.alarm, 1'b0);
`endif

    // Abort during PAUSE
    ifc.dig_tc = 4'h0; ifc.start = 1;
    cyc();
    ifc.start = 0; ifc.stop = 1;
    cyc();
    ifc.stop = 0;
    #1;
    chk("pre_abort_pause", ifc.state, 3'd3);
    ifc.abort = 1; #1;
    chk("abort_clrn", ifc.dig_clrn, 1'b0);
    cyc();
    ifc.abort = 0;
    #1;
    chk("abort_state", ifc.state, 3'd0);
    chk("abort_busy", ifc.busy, 1'b0);
    chk("abort_clrn_rel", ifc.dig_clrn, 1'b1);

    // clr mid-RUN discards the tick
    ifc.start = 1;
    cyc();
    ifc.start = 0;
    #1;
    chk("run2_state", ifc.state, 3'd2);
    clr = 1; ifc.tick = 1; #1;
    chk("clr_run_en", ifc.dig_en, 4'h0);
    chk("clr_run_clrn", ifc.dig_clrn, 1'b0);
    cyc();
    clr = 0; ifc.tick = 0;
    #1;
    chk("clr_run_state", ifc.state, 3'd0);

    // Priority: load_req beats start, abort beats load_req
    ifc.load_req = 1; ifc.start = 1;
    cyc();
    idle_in();
    #1;
    chk("prio_load", ifc.state, 3'd1);
    cyc();
    ifc.abort = 1; ifc.load_req = 1; #1;
    chk("prio_abort_clrn", ifc.dig_clrn, 1'b0);
    cyc();
    idle_in();
    #1;
    chk("prio_abort", ifc.state, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
